// File: rtl/fetch_npc_unit.sv
// fetch_npc_unit: program counter, single-outstanding instruction fetch and
// next-PC selection for the MINIRISC-V core.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_REQ  | fetch request for pc presented, waiting for imem_rdy
// S_WAIT | request accepted, waiting for imem_rvalid
// S_HOLD | instruction held for decode, waiting for inst_ready
// S_HALT | misaligned next PC seen; idle until reset, pc holds the bad npc
module fetch_npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic [1:0]  NpcOp,
    input  logic        br_taken,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        fetch_misalign,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] r_retired_cnt;
    logic [31:0] w_npc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus_imm;
    logic        w_accept;
    logic        w_capture;
    logic        w_npc_misaligned;

    assign w_accept         = (r_state == S_HOLD) && inst_ready;
    assign w_capture        = (r_state == S_WAIT) && imem_rvalid;
    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_pc_plus_imm    = r_pc + imm;
    assign w_npc_misaligned = (w_npc[1:0] != 2'b00);

    // Next-PC select for the held instruction (pc equals inst_pc in S_HOLD).
    always_comb begin
        w_npc = w_pc_plus4;
        case (NpcOp)
            2'b00: w_npc = w_pc_plus4;
            2'b01: w_npc = br_taken ? w_pc_plus_imm : w_pc_plus4;
            2'b10: w_npc = alu_result & ~32'h1;
            2'b11: w_npc = w_pc_plus_imm;
            default: w_npc = w_pc_plus4;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ:  if (imem_rdy)    w_next_state = S_WAIT;
            S_WAIT: if (imem_rvalid) w_next_state = S_HOLD;
            S_HOLD: if (inst_ready)  w_next_state = w_npc_misaligned ? S_HALT : S_REQ;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_REQ;
        endcase
    end

    // State, pc, held instruction and retire counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_inst        <= NOP_INST;
            r_inst_pc     <= RESET_PC;
            r_retired_cnt <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_inst    <= imem_rdata;
                r_inst_pc <= r_pc;
            end
            if (w_accept) begin
                r_inst        <= NOP_INST;
                r_pc          <= w_npc;
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
        end
    end

    // Request is gated by rst_n so it stays low while reset is asserted
    // and rises in the first cycle reset is released.
    assign imem_req       = (r_state == S_REQ) && rst_n;
    assign imem_addr      = r_pc;
    assign inst           = r_inst;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst_pc        = r_inst_pc;
    assign inst_pc4       = r_inst_pc + 32'd4;
    assign fetch_misalign = (r_state == S_HALT);
    assign retired_cnt    = r_retired_cnt;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed bench for fetch_npc_unit: instruction memory handshake is driven
// by hand, expected values are hand-computed per scenario.
module tb_fetch_npc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic [1:0]  NpcOp = 2'b00;
    logic        br_taken = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic        fetch_misalign;
    logic [31:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_npc_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .NpcOp(NpcOp), .br_taken(br_taken), .imm(imm), .alu_result(alu_result),
        .fetch_misalign(fetch_misalign), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch at addr with rdy on the first request cycle and rvalid on the
    // next; leaves the DUT holding word.
    task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] word);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            n_fail++;
            $display("FAIL fetch_req: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, addr);
        end
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_state: req=%b valid=%b, required 0 0", imem_req, inst_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b1 || inst !== word || inst_pc !== addr || inst_pc4 !== addr + 32'd4) begin
            n_fail++;
            $display("FAIL hold_state: valid=%b inst=%h pc=%h pc4=%h, required 1 %h %h %h",
                     inst_valid, inst, inst_pc, inst_pc4, word, addr, addr + 32'd4);
        end
    endtask

    // Accept the held instruction with the given next-PC controls and
    // check the following REQ cycle.
    task automatic accept(input logic [1:0] op, input logic bt, input logic [31:0] im,
                          input logic [31:0] alu, input logic [31:0] exp_npc,
                          input logic [31:0] exp_cnt);
        NpcOp = op; br_taken = bt; imm = im; alu_result = alu;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        NpcOp = 2'b00; br_taken = 1'b0; imm = 32'h0; alu_result = 32'h0;
        n_checks++;
        if (inst_valid !== 1'b0 || inst !== NOP || imem_req !== 1'b1 ||
            imem_addr !== exp_npc || retired_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL accept: valid=%b inst=%h req=%b addr=%h cnt=%0d, required 0 %h 1 %h %0d",
                     inst_valid, inst, imem_req, imem_addr, retired_cnt, NOP, exp_npc, exp_cnt);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst !== NOP || inst_valid !== 1'b0 ||
            inst_pc !== 32'h0 || inst_pc4 !== 32'h4 || fetch_misalign !== 1'b0 ||
            retired_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: req=%b addr=%h inst=%h valid=%b pc=%h pc4=%h mis=%b cnt=%0d, required 0 0 %h 0 0 4 0 0",
                     tag, imem_req, imem_addr, inst, inst_valid, inst_pc, inst_pc4,
                     fetch_misalign, retired_cnt, NOP);
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL req_after_reset: req=%b addr=%h, required 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset_values");
        release_reset();
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            fetch_to_hold(32'(4 * k), 32'h0010_0093 | (32'(k) << 20));
            accept(2'b00, 1'b0, 32'h0, 32'h0, 32'(4 * k + 4), 32'(k + 1));
        end
    endtask

    task automatic test_branch();
        fetch_to_hold(32'h10, 32'hFE00_0CE3);
        accept(2'b01, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h08, 32'd5);
        fetch_to_hold(32'h08, 32'h0080_006F);
        accept(2'b11, 1'b0, 32'h8, 32'h0, 32'h10, 32'd6);
        fetch_to_hold(32'h10, 32'hFE00_0CE3);
        accept(2'b01, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h14, 32'd7);
    endtask

    task automatic test_jal_jalr();
        fetch_to_hold(32'h14, 32'h00C0_006F);
        accept(2'b11, 1'b0, 32'h0C, 32'h0, 32'h20, 32'd8);
        fetch_to_hold(32'h20, 32'h1000_00EF);
        accept(2'b11, 1'b0, 32'h100, 32'h0, 32'h120, 32'd9);
        fetch_to_hold(32'h120, 32'h0000_80E7);
        accept(2'b10, 1'b0, 32'h0, 32'h205, 32'h204, 32'd10);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin
                n_fail++;
                $display("FAIL bp_req_stable: req=%b addr=%h, required 1 204", imem_req, imem_addr);
            end
        end
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_wait: req=%b valid=%b, required 0 0", imem_req, inst_valid);
            end
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_8113;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = (i == 2);
            imem_rdata  = 32'hDEAD_BEEF;
            tick();
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0020_8113 || inst_pc !== 32'h204 || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_stable: valid=%b inst=%h pc=%h req=%b, required 1 00208113 204 0",
                         inst_valid, inst, inst_pc, imem_req);
            end
        end
        imem_rvalid = 1'b0;
        accept(2'b00, 1'b0, 32'h0, 32'h0, 32'h208, 32'd11);
    endtask

    task automatic test_misalign();
        fetch_to_hold(32'h208, 32'hE39F_F06F);
        accept(2'b11, 1'b0, 32'hFFFF_FE38, 32'h0, 32'h40, 32'd12);
        fetch_to_hold(32'h40, 32'h0020_006F);
        NpcOp = 2'b11; imm = 32'h2; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0; NpcOp = 2'b00; imm = 32'h0;
        n_checks++;
        if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
            imem_addr !== 32'h42 || retired_cnt !== 32'd13) begin
            n_fail++;
            $display("FAIL misalign_entry: mis=%b req=%b valid=%b addr=%h cnt=%0d, required 1 0 0 42 13",
                     fetch_misalign, imem_req, inst_valid, imem_addr, retired_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            imem_rdy    = i[0];
            imem_rvalid = i[1];
            inst_ready  = 1'b1;
            tick();
            n_checks++;
            if (imem_req !== 1'b0 || fetch_misalign !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h42) begin
                n_fail++;
                $display("FAIL halt_idle: req=%b mis=%b valid=%b addr=%h, required 0 1 0 42",
                         imem_req, fetch_misalign, inst_valid, imem_addr);
            end
        end
        imem_rdy = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        check_reset_values("misalign_reset");
        release_reset();
    endtask

    task automatic test_reset_in_wait();
        for (int k = 0; k < 7; k++) begin
            fetch_to_hold(32'(4 * k), 32'h0000_0013);
            accept(2'b00, 1'b0, 32'h0, 32'h0, 32'(4 * k + 4), 32'(k + 1));
        end
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0 || retired_cnt !== 32'd7 || imem_addr !== 32'h1C) begin
            n_fail++;
            $display("FAIL pre_reset_wait: req=%b cnt=%0d addr=%h, required 0 7 1c", imem_req, retired_cnt, imem_addr);
        end
        rst_n = 1'b0;
        tick();
        check_reset_values("reset_in_wait");
        release_reset();
        fetch_to_hold(32'h0, 32'h0050_0293);
        accept(2'b00, 1'b0, 32'h0, 32'h0, 32'h4, 32'd1);
    endtask

    task automatic test_reset_in_hold();
        fetch_to_hold(32'h4, 32'h0010_0093);
        inst_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        inst_ready = 1'b0;
        check_reset_values("reset_wins_over_accept");
        release_reset();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal_jalr();
        test_backpressure();
        test_misalign();
        test_reset_in_wait();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_npc_unit.md
# fetch_npc_unit

Instruction-fetch and next-PC unit for the single-issue MINIRISC-V core. It owns the program counter and fetches one 32-bit instruction at a time from instruction memory over a req/rdy + rvalid handshake. It presents that instruction to decode/execute. On acceptance it computes the next PC from the controller's `NpcOp` and the execute-stage results, and fetches again.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `NOP_INST`, default 32'h0000_0013: value of `inst` while no valid instruction is held (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  fetch request; held until `imem_rdy`.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1.
- `imem_rdy`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid; earliest the cycle after the accepting cycle.
- `imem_rdata`  in  32  instruction word.
- `inst`  out  32  held instruction to decode.
- `inst_valid`  out  1  `inst`/`inst_pc`/`inst_pc4` valid.
- `inst_ready`  in  1  decode/execute consumes the instruction this cycle.
- `inst_pc`  out  32  PC of held instruction.
- `inst_pc4`  out  32  `inst_pc`+4, used as the JAL/JALR link value.
- `NpcOp`  in  2  controller next-PC select for the held instruction: 00 seq, 01 branch, 10 JALR, 11 JAL.
- `br_taken`  in  1  branch condition result; used only when `NpcOp`=01.
- `imm`  in  32  sign-extended immediate of the held instruction.
- `alu_result`  in  32  rs1+imm for JALR.
- `fetch_misalign`  out  1  sticky: computed next PC had bits[1:0]≠0.
- `retired_cnt`  out  32  count of accepted instructions.

## Operation
- FSM states: REQ, WAIT, HOLD, HALT.
- REQ: `imem_req`=1, `imem_addr`=pc. On `imem_rdy`=1, go to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`, capture `imem_rdata` into `inst`, set `inst_pc`=pc, set `inst_valid`=1, and go to HOLD.
- HOLD: `inst_valid`=1; outputs are stable. On `inst_ready`=1:
  - compute npc;
  - increment `retired_cnt`;
  - clear `inst_valid`;
  - `inst` returns to `NOP_INST`;
  - load pc=npc and go to REQ, or go to HALT if npc[1:0]≠0.
- npc selection, all arithmetic mod 2^32 with wrap and no carry-out:
  - 00: pc+4
  - 01: `br_taken` ? pc+`imm` : pc+4
  - 10: `alu_result` & ~32'h1
  - 11: pc+`imm`
- HALT: set `fetch_misalign`=1, no requests, `inst_valid`=0. Exit only by reset. `pc` keeps the offending npc for debug.
- `imem_rvalid` outside WAIT is ignored. `NpcOp`, `br_taken`, `imm` and `alu_result` are sampled only on the HOLD acceptance cycle.
- `retired_cnt` wraps from 32'hFFFF_FFFF to 0.
- One outstanding fetch at most. There is no flush input; redirect happens only through `NpcOp` at acceptance.

## Timing
- Reset values (cycle after a `clk` edge with `rst_n`=0):
  - state=REQ, pc=`RESET_PC`
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `inst`=`NOP_INST`, `inst_valid`=0
  - `inst_pc`=`RESET_PC`, `inst_pc4`=`RESET_PC`+4
  - `fetch_misalign`=0, `retired_cnt`=0
- `imem_req` first rises the first cycle `rst_n`=1.
- Request accepted at edge N (req&rdy) → `imem_req`=0 from N+1.
- `imem_rvalid` at edge M → `inst_valid`=1 from M+1. Minimum fetch-to-valid latency is 2 cycles with `imem_rdy`=1 on first request and `imem_rvalid` on the next cycle.
- Acceptance at edge K → `inst_valid`=0 and `imem_req`=1 with new address from K+1. The minimum instruction period is 3 cycles.
- Reset mid-fetch (REQ/WAIT/HOLD): abandons the outstanding fetch and returns to reset values. Instruction memory is reset by the same `rst_n`, so no stale `imem_rvalid` follows.
- `inst_valid` and `inst_ready` in the same cycle as `rst_n`=0: reset wins; `retired_cnt` not incremented.

## Test plan
- Reset then sequential: `RESET_PC`=0, memory returns `addi` words with `imem_rdy`=1 and `imem_rvalid` one cycle later, `NpcOp`=00, `inst_ready`=1 → `imem_addr` sequence 0,4,8,C; a new `inst_valid` every 3 cycles; `retired_cnt`=4 after four acceptances.
- Branch: `inst_pc`=0x10, `NpcOp`=01, `imm`=0xFFFF_FFF8. With `br_taken`=1 → next `imem_addr`=0x08. Repeat with `br_taken`=0 → next `imem_addr`=0x14.
- JAL/JALR: `NpcOp`=11, `inst_pc`=0x20, `imm`=0x100 → next fetch 0x120 and `inst_pc4`=0x24. Then `NpcOp`=10, `alu_result`=0x205 → next fetch 0x204.
- Backpressure: `imem_rdy` low for 3 cycles, then `imem_rvalid` 4 cycles later, then `inst_ready` low for 5 cycles → `imem_addr` stable while `imem_req`=1; `inst` and `inst_pc` stable throughout HOLD; stray `imem_rvalid` in HOLD is ignored.
- Misalign: `NpcOp`=11, pc=0x40, `imm`=0x2 → `fetch_misalign`=1 from the cycle after acceptance; `imem_req` stays 0 for ≥20 cycles; reset clears it.
- Reset during WAIT with `retired_cnt`=7 → all outputs return to reset values next cycle; fetch restarts at `RESET_PC`.
